qspi_psram_responder: RTL and testbench



---
 rtl/qspi_psram_pkg.sv | 19 +
 rtl/qspi_psram_responder_edge_sync.sv | 50 +++++
 rtl/qspi_psram_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_qspi_psram_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_psram_pkg.sv
`timescale 1ns/1ps
// Shared command codes, address framing and FSM state type for the QSPI PSRAM responder.
package qspi_psram_pkg;

  localparam logic [7:0]  CMD_QREAD    = 8'hEB;
  localparam logic [7:0]  CMD_QWRITE   = 8'h38;
  localparam int unsigned ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } state_e;

endpackage

// File: rtl/qspi_psram_responder_edge_sync.sv
`timescale 1ns/1ps
// qspi_edge_sync: brings sck, ce_n and the data lanes into the clk domain and
// produces single-cycle sck rise/fall pulses from the last two synchronized samples.
module qspi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] d_in,
  output logic       sck_rise_c,
  output logic       sck_fall_c,
  output logic       ce_n_sync,
  output logic [3:0] d_sync
);

  logic [SYNC_STAGES-1:0]      sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]      ce_sync_q, ce_sync_d;
  logic [SYNC_STAGES-1:0][3:0] d_sync_q, d_sync_d;
  logic                        sck_prev_q, sck_prev_d;

  // Equal-depth chains keep data aligned with the sck edge that qualifies it.
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ce_sync_d  = {ce_sync_q[SYNC_STAGES-2:0], ce_n};
    d_sync_d   = {d_sync_q[SYNC_STAGES-2:0], d_in};
    sck_prev_d = sck_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      ce_sync_q  <= '1;
      d_sync_q   <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ce_sync_q  <= ce_sync_d;
      d_sync_q   <= d_sync_d;
      sck_prev_q <= sck_prev_d;
    end
  end

  assign sck_rise_c = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall_c = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
  assign ce_n_sync  = ce_sync_q[SYNC_STAGES-1];
  assign d_sync     = d_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/qspi_psram_responder.sv
`timescale 1ns/1ps
// QSPI PSRAM target backed by a byte array: quad read (0xEB) and quad write (0x38).
// Define QSPI_RESP_CMD_ERR_EN to build the sticky cmd_err flag for unsupported commands.
module qspi_psram_responder
  import qspi_psram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DUMMY_CYC   = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       psram_sck,
  input  logic       psram_ce_n,
  input  logic [3:0] psram_d_in,
  output logic [3:0] psram_d_out,
  output logic [3:0] psram_d_oe,
  output logic       cmd_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned DUM_W = (DUMMY_CYC > 0) ? $clog2(DUMMY_CYC + 1) : 1;

  logic             sck_rise_c, sck_fall_c, ce_n_s;
  logic [3:0]       d_s;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [DUM_W-1:0] dum_q, dum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic             is_rd_q, is_rd_d;
  logic             half_q, half_d;
  logic [3:0]       whi_q, whi_d;
  logic [3:0]       d_out_q, d_out_d;
  logic [3:0]       d_oe_q, d_oe_d;

  logic [ADDR_W-1:0] addr_shift_c;
  logic [ADDR_W-1:0] rd_sel_c;
  logic [7:0]        rd_byte_c;
  logic              mem_we_c;
  logic [7:0]        mem_wdata_c;

  logic [7:0] mem [DEPTH];

  qspi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (psram_sck),
    .ce_n      (psram_ce_n),
    .d_in      (psram_d_in),
    .sck_rise_c(sck_rise_c),
    .sck_fall_c(sck_fall_c),
    .ce_n_sync (ce_n_s),
    .d_sync    (d_s)
  );

  // Read port: the last address nibble is folded in so a zero-dummy read can preload.
  always_comb begin
    addr_shift_c = ADDR_W'({addr_q, d_s});
    rd_sel_c     = (state_q == ADDR) ? addr_shift_c : addr_q;
    rd_byte_c    = mem[rd_sel_c];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    dum_d       = dum_q;
    addr_d      = addr_q;
    is_rd_d     = is_rd_q;
    half_d      = half_q;
    whi_d       = whi_q;
    d_out_d     = d_out_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = {whi_q, d_s};

    if (ce_n_s) begin
      // Deselect beats any coincident sck edge and drops a half-built write byte.
      state_d = IDLE;
      cnt_d   = '0;
      dum_d   = '0;
      half_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
          cmd_d   = '0;
          dum_d   = '0;
          half_d  = 1'b0;
        end
        CMD: begin
          if (sck_rise_c) begin
            cmd_d = {cmd_q[6:0], d_s[0]};
            cnt_d = 3'(cnt_q + 3'd1);
            if (cnt_q == 3'd7) begin
              cnt_d = '0;
              if (cmd_d == CMD_QREAD) begin
                state_d = ADDR;
                is_rd_d = 1'b1;
              end else if (cmd_d == CMD_QWRITE) begin
                state_d = ADDR;
                is_rd_d = 1'b0;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR: begin
          if (sck_rise_c) begin
            addr_d = addr_shift_c;
            cnt_d  = 3'(cnt_q + 3'd1);
            if (cnt_q == 3'(ADDR_NIBBLES - 1)) begin
              cnt_d  = '0;
              half_d = 1'b0;
              if (!is_rd_q) begin
                state_d = WDATA;
              end else if (DUMMY_CYC == 0) begin
                state_d = RDATA;
              end else begin
                state_d = DUMMY;
              end
            end
          end
        end
        DUMMY: begin
          if (sck_rise_c) begin
            dum_d = DUM_W'(dum_q + DUM_W'(1));
            if (dum_d == DUM_W'(DUMMY_CYC)) state_d = RDATA;
          end
        end
        RDATA: begin
          // Each fall drives the nibble under the pointer, then advances it.
          if (sck_fall_c) begin
            d_out_d = half_q ? rd_byte_c[3:0] : rd_byte_c[7:4];
            if (half_q) begin
              half_d = 1'b0;
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              half_d = 1'b1;
            end
          end
        end
        WDATA: begin
          if (sck_rise_c) begin
            if (!half_q) begin
              whi_d  = d_s;
              half_d = 1'b1;
            end else begin
              mem_we_c = 1'b1;
              half_d   = 1'b0;
              addr_d   = addr_q + ADDR_W'(1);
            end
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Preload the first high nibble so it is stable before the first data rise.
    if (state_d == RDATA) begin
      if (state_q != RDATA) begin
        d_out_d = rd_byte_c[7:4];
        half_d  = 1'b0;
      end
    end else begin
      d_out_d = '0;
    end
    d_oe_d = (state_d == RDATA) ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      dum_q   <= '0;
      addr_q  <= '0;
      is_rd_q <= 1'b0;
      half_q  <= 1'b0;
      whi_q   <= '0;
      d_out_q <= '0;
      d_oe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      dum_q   <= dum_d;
      addr_q  <= addr_d;
      is_rd_q <= is_rd_d;
      half_q  <= half_d;
      whi_q   <= whi_d;
      d_out_q <= d_out_d;
      d_oe_q  <= d_oe_d;
    end
  end

  // Backing array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[addr_q] <= mem_wdata_c;
  end

  assign psram_d_out = d_out_q;
  assign psram_d_oe  = d_oe_q;

`ifdef QSPI_RESP_CMD_ERR_EN
  logic cmd_err_q, cmd_err_d;

  always_comb begin
    cmd_err_d = cmd_err_q;
    if (state_d == IGNORE && state_q != IGNORE) cmd_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_err_q <= 1'b0;
    else        cmd_err_q <= cmd_err_d;
  end

  assign cmd_err = cmd_err_q;
`else
  assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_psram_responder.sv
`timescale 1ns/1ps
// Bench for qspi_psram_responder: a QSPI master model drives transactions, a byte-array
// reference model predicts read nibbles, and a monitor pops and compares them.
module tb_qspi_psram_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam int          DUMMY  = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psram_sck;
  logic       psram_ce_n;
  logic [3:0] psram_d_in;
  logic [3:0] psram_d_out;
  logic [3:0] psram_d_oe;
  logic       cmd_err;

  qspi_psram_responder #(
    .ADDR_W     (ADDR_W),
    .DUMMY_CYC  (DUMMY),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psram_sck  (psram_sck),
    .psram_ce_n (psram_ce_n),
    .psram_d_in (psram_d_in),
    .psram_d_out(psram_d_out),
    .psram_d_oe (psram_d_oe),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  int         smp_mode = 0;   // 0 none, 1 expect bus released, 2 expect read nibble
  int         half_clk = 3;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] wbytes[$];

  function automatic logic [9:0] wrap(input int v);
    return 10'(v % DEPTH);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples at the end of each SCK high phase the master asked about.
  always @(posedge clk) begin
    #1;
    if (smp_mode == 2) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_nibble: got %h with no expected nibble queued", psram_d_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (psram_d_out !== mon_exp) begin
          n_bad++;
          $display("FAIL rd_nibble: got %h expected %h", psram_d_out, mon_exp);
        end
      end
      n_cmp++;
      if (psram_d_oe !== 4'hF) begin
        n_bad++;
        $display("FAIL rd_oe: got %h expected f", psram_d_oe);
      end
    end else if (smp_mode == 1) begin
      n_cmp++;
      if (psram_d_oe !== 4'h0) begin
        n_bad++;
        $display("FAIL oe_released: got %h expected 0", psram_d_oe);
      end
    end
  end

  task automatic pulse(input logic [3:0] d, input int mode);
    psram_sck  = 1'b0;
    psram_d_in = d;
    repeat (half_clk) @(negedge clk);
    psram_sck = 1'b1;
    repeat (half_clk - 1) @(negedge clk);
    smp_mode = mode;
    @(negedge clk);
    smp_mode = 0;
  endtask

  task automatic begin_txn();
    psram_ce_n = 1'b0;
    psram_sck  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_txn();
    if ($urandom_range(0, 1) == 1) begin
      psram_sck  = 1'b0;
      psram_ce_n = 1'b1;
    end else begin
      psram_sck = 1'b0;
      repeat (half_clk) @(negedge clk);
      psram_ce_n = 1'b1;
    end
    repeat (3 + $urandom_range(0, 4)) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) pulse({3'($urandom), c[i]}, 1);
  endtask

  task automatic send_addr(input logic [9:0] a);
    logic [23:0] full;
    full = {14'($urandom), a};
    for (int n = 5; n >= 0; n--) pulse(full[n*4 +: 4], 1);
  endtask

  task automatic write_burst(input logic [9:0] a);
    begin_txn();
    send_cmd(8'h38);
    send_addr(a);
    foreach (wbytes[i]) begin
      pulse(wbytes[i][7:4], 1);
      pulse(wbytes[i][3:0], 1);
      ref_mem[wrap(int'(a) + i)] = wbytes[i];
    end
    end_txn();
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_oe", 8'(psram_d_oe), 8'h00);
    check("rst_async_dout", 8'(psram_d_out), 8'h00);
    exp_q.delete();
    psram_ce_n = 1'b1;
    psram_sck  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_burst(input logic [9:0] a, input int n, input int abort_nib);
    logic [7:0] b;
    begin_txn();
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < DUMMY; i++) pulse(4'($urandom), (i < DUMMY - 1) ? 1 : 0);
    for (int i = 0; i < 2 * n; i++) begin
      if (i == abort_nib) begin
        reset_mid();
        return;
      end
      b = ref_mem[wrap(int'(a) + i / 2)];
      exp_q.push_back((i % 2 == 0) ? b[7:4] : b[3:0]);
      pulse(4'($urandom), 2);
    end
    end_txn();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_err;
    logic [9:0] bases[$];
    int         lens[$];
    int         total;
    int         len;
    logic [9:0] base;

`ifdef QSPI_RESP_CMD_ERR_EN
    exp_err = 8'h01;
`else
    exp_err = 8'h00;
`endif

    rst_n      = 1'b0;
    psram_sck  = 1'b0;
    psram_ce_n = 1'b1;
    psram_d_in = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_oe", 8'(psram_d_oe), 8'h00);
    check("reset_dout", 8'(psram_d_out), 8'h00);
    check("reset_cmd_err", 8'(cmd_err), 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    half_clk = 3;
    wbytes = {8'hA5, 8'h3C};
    write_burst(10'h010);
    read_burst(10'h010, 2, -1);

    wbytes = {8'h5A, 8'hC3};
    write_burst(10'h3FF);
    read_burst(10'h3FF, 2, -1);
    read_burst(10'h000, 1, -1);

    begin_txn();
    send_cmd(8'h9F);
    for (int i = 0; i < 6; i++) pulse(4'($urandom), 1);
    end_txn();
    check("cmd_err_unknown", 8'(cmd_err), exp_err);
    read_burst(10'h010, 2, -1);
    read_burst(10'h3FF, 2, -1);

    begin_txn();
    send_cmd(8'h38);
    send_addr(10'h010);
    pulse(4'h7, 1);
    end_txn();
    read_burst(10'h010, 2, -1);

    wbytes = {8'h12, 8'h34, 8'h56, 8'h78};
    write_burst(10'h020);
    read_burst(10'h020, 4, 3);
    check("cmd_err_after_reset", 8'(cmd_err), 8'h00);
    read_burst(10'h020, 4, -1);
    read_burst(10'h010, 2, -1);

    half_clk = 2;
    total = 0;
    while (total < 256) begin
      len = int'($urandom_range(1, 16));
      if (total + len > 256) len = 256 - total;
      base = 10'($urandom);
      wbytes.delete();
      for (int i = 0; i < len; i++) wbytes.push_back(8'($urandom));
      write_burst(base);
      bases.push_back(base);
      lens.push_back(len);
      total += len;
    end
    foreach (bases[k]) read_burst(bases[k], lens[k], -1);

    repeat (5) @(negedge clk);
    check("leftover_expected", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
